// File: rtl/riscv_decode_stage.sv
// RV32I/RV64I decode stage: registered bundle, 1-entry skid, flush, illegal count.
// Ports: i_clk/i_rst; i_valid/o_ready/i_instr/i_pc/i_flush upstream; o_valid/i_ready + decoded bundle downstream.
module riscv_decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [31:0]      i_instr,
  input  logic [XLEN-1:0]  i_pc,
  input  logic             i_flush,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [XLEN-1:0]  o_pc,
  output logic [4:0]       o_rs1,
  output logic [4:0]       o_rs2,
  output logic [4:0]       o_rd,
  output logic [2:0]       o_imm_src,
  output logic [XLEN-1:0]  o_imm,
  output logic             o_reg_write,
  output logic             o_mem_write,
  output logic             o_alu_src,
  output logic             o_branch,
  output logic             o_jump,
  output logic [1:0]       o_result_src,
  output logic [1:0]       o_alu_op,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_illegal_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      imm_src;
    logic [XLEN-1:0] imm;
    logic            reg_write;
    logic            mem_write;
    logic            alu_src;
    logic            branch;
    logic            jump;
    logic [1:0]      result_src;
    logic [1:0]      alu_op;
    logic            illegal;
  } bundle_t;

  logic [6:0]  op;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;
  logic        is_load;
  logic        is_opimm;
  logic        is_jalr;
  logic        is_store;
  logic        is_branch;
  logic        is_rtype;
  logic        is_upper;
  logic        is_jal;

  bundle_t dec;
  bundle_t out_q;
  bundle_t skid_q;
  logic    out_vld;
  logic    skid_vld;
  logic [CNT_W-1:0] cnt;

  logic accept;
  logic xfer;
  logic load_out;

  assign op = i_instr[6:0];

  assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_s = {{20{i_instr[31]}}, i_instr[31:25],
                  i_instr[11:7]};
  assign imm_b = {{19{i_instr[31]}}, i_instr[31],
                  i_instr[7], i_instr[30:25],
                  i_instr[11:8], 1'b0};
  assign imm_u = {i_instr[31:12], 12'b0};
  assign imm_j = {{11{i_instr[31]}}, i_instr[31],
                  i_instr[19:12], i_instr[20],
                  i_instr[30:21], 1'b0};

  assign is_load   = op == 7'b0000011;
  assign is_opimm  = op == 7'b0010011;
  assign is_jalr   = op == 7'b1100111;
  assign is_store  = op == 7'b0100011;
  assign is_branch = op == 7'b1100011;
  assign is_rtype  = op == 7'b0110011;
  assign is_upper  = (op == 7'b0110111)
                   || (op == 7'b0010111);
  assign is_jal    = op == 7'b1101111;

  always_comb begin
    dec         = '0;
    dec.pc      = i_pc;
    dec.rs1     = i_instr[19:15];
    dec.rs2     = i_instr[24:20];
    dec.rd      = i_instr[11:7];
    dec.imm_src = 3'b011;
    unique case (1'b1)
      is_load: begin
        dec.imm_src    = 3'b000;
        dec.imm        = XLEN'($signed(imm_i));
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b01;
      end
      is_opimm: begin
        dec.imm_src   = 3'b000;
        dec.imm       = XLEN'($signed(imm_i));
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = 2'b10;
      end
      is_jalr: begin
        dec.imm_src    = 3'b000;
        dec.imm        = XLEN'($signed(imm_i));
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = 2'b10;
      end
      is_store: begin
        dec.imm_src   = 3'b001;
        dec.imm       = XLEN'($signed(imm_s));
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      is_branch: begin
        dec.imm_src = 3'b010;
        dec.imm     = XLEN'($signed(imm_b));
        dec.branch  = 1'b1;
        dec.alu_op  = 2'b01;
      end
      is_rtype: begin
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
      end
      is_upper: begin
        dec.imm_src   = 3'b100;
        dec.imm       = XLEN'($signed(imm_u));
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      is_jal: begin
        dec.imm_src    = 3'b101;
        dec.imm        = XLEN'($signed(imm_j));
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = 2'b10;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  // The skid can only fill while o_ready is high, so an
  // accept never coincides with a full skid.
  assign accept   = i_valid && o_ready;
  assign xfer     = out_vld && i_ready;
  assign load_out = !out_vld || xfer;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_q         <= '0;
      out_q.imm_src <= 3'b011;
      skid_q        <= '0;
      out_vld       <= 1'b0;
      skid_vld      <= 1'b0;
      cnt           <= '0;
    end else begin
      if (i_flush) begin
        out_vld  <= 1'b0;
        skid_vld <= 1'b0;
      end else if (load_out) begin
        if (skid_vld) begin
          out_q    <= skid_q;
          out_vld  <= 1'b1;
          skid_vld <= 1'b0;
        end else begin
          out_vld <= accept;
          if (accept) out_q <= dec;
        end
      end else if (accept) begin
        skid_q   <= dec;
        skid_vld <= 1'b1;
      end
      if (accept && !i_flush && dec.illegal
          && cnt != {CNT_W{1'b1}})
        cnt <= cnt + 1'b1;
    end
  end

  assign o_ready       = !skid_vld;
  assign o_valid       = out_vld;
  assign o_pc          = out_q.pc;
  assign o_rs1         = out_q.rs1;
  assign o_rs2         = out_q.rs2;
  assign o_rd          = out_q.rd;
  assign o_imm_src     = out_q.imm_src;
  assign o_imm         = out_q.imm;
  assign o_reg_write   = out_q.reg_write;
  assign o_mem_write   = out_q.mem_write;
  assign o_alu_src     = out_q.alu_src;
  assign o_branch      = out_q.branch;
  assign o_jump        = out_q.jump;
  assign o_result_src  = out_q.result_src;
  assign o_alu_op      = out_q.alu_op;
  assign o_illegal     = out_q.illegal;
  assign o_illegal_cnt = cnt;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Directed bench for riscv_decode_stage (XLEN=32 and XLEN=64 instances).
// Drives shared stimulus and compares against hand-computed values.
module tb_riscv_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        flush;
  logic        ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [63:0] pc64;

  logic        o_ready, o_valid;
  logic [31:0] o_pc, o_imm;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [2:0]  o_imm_src;
  logic        o_reg_write, o_mem_write, o_alu_src;
  logic        o_branch, o_jump, o_illegal;
  logic [1:0]  o_result_src, o_alu_op;
  logic [7:0]  o_cnt;

  logic        w_ready, w_valid;
  logic [63:0] w_pc, w_imm;
  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [2:0]  w_imm_src;
  logic        w_reg_write, w_mem_write, w_alu_src;
  logic        w_branch, w_jump, w_illegal;
  logic [1:0]  w_result_src, w_alu_op;
  logic [7:0]  w_cnt;

  int total = 0;
  int bad   = 0;

  assign pc64 = {32'b0, pc};

  always #5 clk = ~clk;

  riscv_decode_stage #(.XLEN(32), .CNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_valid(valid), .o_ready(o_ready),
    .i_instr(instr), .i_pc(pc),
    .i_flush(flush),
    .o_valid(o_valid), .i_ready(ready),
    .o_pc(o_pc),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd),
    .o_imm_src(o_imm_src), .o_imm(o_imm),
    .o_reg_write(o_reg_write),
    .o_mem_write(o_mem_write),
    .o_alu_src(o_alu_src),
    .o_branch(o_branch), .o_jump(o_jump),
    .o_result_src(o_result_src),
    .o_alu_op(o_alu_op),
    .o_illegal(o_illegal),
    .o_illegal_cnt(o_cnt)
  );

  riscv_decode_stage #(.XLEN(64), .CNT_W(8)) dut64 (
    .i_clk(clk), .i_rst(rst),
    .i_valid(valid), .o_ready(w_ready),
    .i_instr(instr), .i_pc(pc64),
    .i_flush(flush),
    .o_valid(w_valid), .i_ready(ready),
    .o_pc(w_pc),
    .o_rs1(w_rs1), .o_rs2(w_rs2), .o_rd(w_rd),
    .o_imm_src(w_imm_src), .o_imm(w_imm),
    .o_reg_write(w_reg_write),
    .o_mem_write(w_mem_write),
    .o_alu_src(w_alu_src),
    .o_branch(w_branch), .o_jump(w_jump),
    .o_result_src(w_result_src),
    .o_alu_op(w_alu_op),
    .o_illegal(w_illegal),
    .o_illegal_cnt(w_cnt)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] ins,
                      input logic [31:0] p);
    valid = 1'b1;
    instr = ins;
    pc    = p;
    step();
    valid = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    valid = 1'b0;
    flush = 1'b0;
    ready = 1'b1;
    instr = '0;
    pc    = '0;
    #2;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_immsrc", 64'(o_imm_src), 64'd3);
    chk("rst_imm", 64'(o_imm), 64'd0);
    chk("rst_cnt", 64'(o_cnt), 64'd0);
    chk("rst_rw", 64'(o_reg_write), 64'd0);
    step();
    rst = 1'b0;

    send(32'h00812283, 32'h1000);
    chk("lw_valid", 64'(o_valid), 64'd1);
    chk("lw_rd", 64'(o_rd), 64'd5);
    chk("lw_rs1", 64'(o_rs1), 64'd2);
    chk("lw_imm", 64'(o_imm), 64'd8);
    chk("lw_immsrc", 64'(o_imm_src), 64'd0);
    chk("lw_res", 64'(o_result_src), 64'd1);
    chk("lw_rw", 64'(o_reg_write), 64'd1);
    chk("lw_pc", 64'(o_pc), 64'h1000);

    send(32'hFE512E23, 32'h1004);
    chk("sw_immsrc", 64'(o_imm_src), 64'd1);
    chk("sw_imm", 64'(o_imm), 64'hFFFFFFFC);
    chk("sw_mw", 64'(o_mem_write), 64'd1);
    chk("sw_rw", 64'(o_reg_write), 64'd0);
    chk("sw_imm64", w_imm, 64'hFFFFFFFFFFFFFFFC);

    send(32'hFE208CE3, 32'h1008);
    chk("beq_immsrc", 64'(o_imm_src), 64'd2);
    chk("beq_imm", 64'(o_imm), 64'hFFFFFFF8);
    chk("beq_br", 64'(o_branch), 64'd1);
    chk("beq_aluop", 64'(o_alu_op), 64'd1);

    send(32'h001000EF, 32'h100C);
    chk("jal_immsrc", 64'(o_imm_src), 64'd5);
    chk("jal_imm", 64'(o_imm), 64'h800);
    chk("jal_jump", 64'(o_jump), 64'd1);
    chk("jal_res", 64'(o_result_src), 64'd2);
    chk("jal_rd", 64'(o_rd), 64'd1);

    send(32'h002081B3, 32'h1010);
    chk("add_immsrc", 64'(o_imm_src), 64'd3);
    chk("add_imm", 64'(o_imm), 64'd0);
    chk("add_aluop", 64'(o_alu_op), 64'd2);
    chk("add_rs2", 64'(o_rs2), 64'd2);

    step();
    chk("drain_valid", 64'(o_valid), 64'd0);

    ready = 1'b0;
    valid = 1'b1;
    instr = 32'h00500093;
    pc    = 32'h100;
    step();
    chk("st1_ready", 64'(o_ready), 64'd1);
    chk("st1_pc", 64'(o_pc), 64'h100);
    pc = 32'h104;
    step();
    chk("st2_ready", 64'(o_ready), 64'd0);
    chk("st2_pc", 64'(o_pc), 64'h100);
    pc = 32'h108;
    step();
    chk("st3_ready", 64'(o_ready), 64'd0);
    chk("st3_pc", 64'(o_pc), 64'h100);
    valid = 1'b0;
    ready = 1'b1;
    step();
    chk("rel_pc", 64'(o_pc), 64'h104);
    chk("rel_valid", 64'(o_valid), 64'd1);
    chk("rel_ready", 64'(o_ready), 64'd1);
    step();
    chk("rel_empty", 64'(o_valid), 64'd0);

    ready = 1'b0;
    send(32'h00500093, 32'h200);
    send(32'h00600093, 32'h204);
    chk("fl_full", 64'(o_ready), 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_valid", 64'(o_valid), 64'd0);
    chk("fl_ready", 64'(o_ready), 64'd1);
    ready = 1'b1;
    step();
    chk("fl_noskid", 64'(o_valid), 64'd0);

    send(32'h0, 32'h300);
    chk("ill_flag", 64'(o_illegal), 64'd1);
    chk("ill_immsrc", 64'(o_imm_src), 64'd3);
    chk("ill_imm", 64'(o_imm), 64'd0);
    chk("ill_strobes",
        64'({o_reg_write, o_mem_write, o_alu_src,
             o_branch, o_jump, o_result_src,
             o_alu_op}), 64'd0);
    chk("ill_cnt1", 64'(o_cnt), 64'd1);

    flush = 1'b1;
    send(32'h0, 32'h304);
    flush = 1'b0;
    chk("ill_flcnt", 64'(o_cnt), 64'd1);
    chk("ill_flvalid", 64'(o_valid), 64'd0);

    valid = 1'b1;
    instr = 32'h0;
    for (int i = 0; i < 300; i++) step();
    valid = 1'b0;
    chk("ill_sat", 64'(o_cnt), 64'd255);
    chk("ill_sat64", 64'(w_cnt), 64'd255);

    ready = 1'b0;
    send(32'h00500093, 32'h400);
    send(32'h00600093, 32'h404);
    chk("mr_full", 64'(o_ready), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_valid", 64'(o_valid), 64'd0);
    chk("mr_ready", 64'(o_ready), 64'd1);
    chk("mr_cnt", 64'(o_cnt), 64'd0);
    chk("mr_pc", 64'(o_pc), 64'd0);
    rst   = 1'b0;
    ready = 1'b1;
    step();
    chk("mr_after", 64'(o_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
